// File: rtl/mm_access_ctrl.sv
// mm_access_ctrl: data-memory access controller sitting in the MEM stage.
//
// A load or store presented by the EX/MEM register stalls the pipeline,
// issues a single registered request to the data memory, waits for dhit,
// captures load data, and then releases the pipeline for exactly one cycle.
// A halt from EX/MEM parks the controller in HALTED until reset.
//
// Optional feature (macro MM_TIMEOUT_EN): an ACCESS watchdog that aborts
// after TIMEOUT_CYCLES cycles without dhit. It sets the sticky mm_err flag
// and returns 32'hBAD0BAD0 for loads. With the macro undefined there is no
// counter, ACCESS waits forever and mm_err is tied low.
//
// Ports:
//   CLK, nRST            clock (rising edge), async active-low reset
//   dRENi, dWENi, halt   load/store/halt requests from EX/MEM
//   ALUOut, store        effective address and store data
//   dhit, dload          memory completion strobe and read data
//   dmemREN, dmemWEN     memory read/write request (ACCESS only)
//   dmemaddr, dmemstore  word-aligned address and store data, registered
//   mmload               captured load data for MEM/WB
//   pipe_en              pipeline register enable (0 = stall)
//   halt_out             sticky halt indication
//   mm_err               sticky timeout error
//   state_dbg            current FSM state (IDLE=0 ACCESS=1 DONE=2 HALTED=3)
//
// Request handshake: a request is accepted in IDLE whenever dRENi|dWENi is
// high and halt is low; the EX/MEM inputs are expected to stay stable while
// pipe_en is 0, and the transfer completes on the first ACCESS cycle with
// dhit=1 (or on timeout, when enabled).

module mm_access_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dRENi,
    input  logic        dWENi,
    input  logic        halt,
    input  logic [31:0] ALUOut,
    input  logic [31:0] store,
    input  logic        dhit,
    input  logic [31:0] dload,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore,
    output logic [31:0] mmload,
    output logic        pipe_en,
    output logic        halt_out,
    output logic        mm_err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t state, next_state;
    logic   is_store;   // operation type latched on entry to ACCESS
    logic   start;      // IDLE -> ACCESS this cycle
    logic   timeout;    // watchdog expiry in the current ACCESS cycle

    assign state_dbg = state;
    // HALTED is only left through reset, so this is sticky by construction.
    assign halt_out  = (state == HALTED);

    always_comb begin
        next_state = state;
        pipe_en    = 1'b1;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (halt) begin
                    next_state = HALTED;
                    pipe_en    = 1'b0;
                end else if (dRENi || dWENi) begin
                    next_state = ACCESS;
                    pipe_en    = 1'b0;
                    start      = 1'b1;
                end
            end
            ACCESS: begin
                pipe_en = 1'b0;
                // A simultaneous load+store request was latched as a store.
                dmemWEN = is_store;
                dmemREN = !is_store;
                if (dhit || timeout) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            HALTED:  pipe_en    = 1'b0;
            default: next_state = IDLE;
        endcase
        // While reset is held the pipeline is released regardless of inputs.
        if (!nRST) pipe_en = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            is_store  <= 1'b0;
            dmemaddr  <= 32'd0;
            dmemstore <= 32'd0;
            mmload    <= 32'd0;
        end else begin
            state <= next_state;
            if (start) begin
                is_store  <= dWENi;
                dmemaddr  <= {ALUOut[31:2], 2'b00};
                dmemstore <= store;
            end
            if (state == ACCESS && !is_store) begin
                if (dhit)         mmload <= dload;
                else if (timeout) mmload <= 32'hBAD0BAD0;
            end
        end
    end

`ifdef MM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] to_cnt;   // 1 in the first ACCESS cycle, 0 outside ACCESS

    assign timeout = (state == ACCESS) && (to_cnt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            to_cnt <= '0;
            mm_err <= 1'b0;
        end else begin
            if (start)
                to_cnt <= CW'(1);
            else if (state == ACCESS && !dhit && !timeout)
                to_cnt <= to_cnt + CW'(1);
            else
                to_cnt <= '0;
            // dhit in the expiry cycle counts as a normal completion.
            if (timeout && !dhit) mm_err <= 1'b1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^ALUOut[1:0];
`else
    assign timeout = 1'b0;
    assign mm_err  = 1'b0;

    logic unused_bits;
    assign unused_bits = ^ALUOut[1:0] ^ (TIMEOUT_CYCLES == 0);
`endif

endmodule
